// File: rtl/vc_test_rand_pkg.sv
// Shared constants and types for the random-delay test harness blocks:
// LFSR polynomial, default seed, the one-step LFSR function and the
// arbiter state encoding.
package vc_test_rand_pkg;

   // Galois feedback taps, applied when the bit shifted out is 1.
   localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hB7E1_5163;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DELAY = 1'b1
   } arb_state_e;

   // One right-shifting Galois step.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/vc_test_lfsr32.sv
// 32-bit Galois LFSR. Reusable by any random-delay test block that has to
// share one reproducible pseudo-random sequence.
module vc_test_lfsr32
   import vc_test_rand_pkg::*;
#(
   parameter logic [31:0] p_seed = LFSR_SEED_DEFAULT
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   output logic [31:0] q
);

   logic [31:0] r_q;

   // Sequence register: seed on reset, one step per enabled cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= p_seed;
      end else if (en) begin
         r_q <= lfsr_step(r_q);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/vc_test_rand_delay_arb.sv
// Round-robin val/rdy arbiter with a pseudo-random hold-off before every
// grant. Once a winner is latched it cannot be preempted until it transfers.
// Optional source-protocol checker: define VC_TEST_RAND_DELAY_ARB_CHECK_EN to
// build the sticky err flag; otherwise err is tied low.
module vc_test_rand_delay_arb
   import vc_test_rand_pkg::*;
#(
   parameter int unsigned p_num_ports = 4,
   parameter int unsigned p_msg_sz    = 8,
   parameter int unsigned p_max_delay = 0,
   parameter logic [31:0] p_seed      = LFSR_SEED_DEFAULT
)(
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [p_num_ports-1:0]            in_val,
   output logic [p_num_ports-1:0]            in_rdy,
   input  logic [p_num_ports*p_msg_sz-1:0]   in_msg,
   output logic                              out_val,
   input  logic                              out_rdy,
   output logic [p_msg_sz-1:0]               out_msg,
   output logic [$clog2(p_num_ports)-1:0]    out_sel,
   output logic [31:0]                       rand_num,
   output logic                              err
);

   localparam int unsigned SEL_W = $clog2(p_num_ports);
   // The counter only ever holds rand_num-1, i.e. at most p_max_delay-1.
   localparam int unsigned CNT_W = (p_max_delay > 1) ? $clog2(p_max_delay + 1) : 1;

   localparam logic [SEL_W:0]   NP_EXT   = p_num_ports[SEL_W:0];
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(p_num_ports - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_e        r_state;
   arb_state_e        w_state_next;
   logic [SEL_W-1:0]  r_ptr;
   logic [SEL_W-1:0]  w_ptr_next;
   logic [SEL_W-1:0]  r_win;
   logic [SEL_W-1:0]  w_win_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;

   logic [31:0]       w_lfsr;
   logic [31:0]       w_rand;
   logic              w_found;
   logic [SEL_W-1:0]  w_winner;
   logic [SEL_W-1:0]  w_winner_inc;
   logic [SEL_W-1:0]  w_win_inc;
   logic [SEL_W-1:0]  w_sel;
   logic              w_out_val;
   logic              w_grant;

   logic [p_msg_sz-1:0] w_msg_arr [p_num_ports];

   // ------------------------------------------------------------------
   // Random source and bounded random number
   // ------------------------------------------------------------------
   vc_test_lfsr32 #(
      .p_seed (p_seed)
   ) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (1'b1),
      .q       (w_lfsr)
   );

   generate
      if (p_max_delay == 0) begin : g_no_delay
         assign w_rand = 32'h0000_0000;
      end else begin : g_delay
         assign w_rand = w_lfsr % 32'(p_max_delay + 1);
      end
   endgenerate

   assign rand_num = w_rand;

   // ------------------------------------------------------------------
   // Message unpacking
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < p_num_ports; gi++) begin : g_msg
         assign w_msg_arr[gi] = in_msg[gi*p_msg_sz +: p_msg_sz];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Round-robin find-first starting at r_ptr
   // ------------------------------------------------------------------
   // Scan from r_ptr upward with wrap; the first valid source wins.
   always_comb begin : find_first
      logic [SEL_W:0] v_idx;
      v_idx    = '0;
      w_found  = 1'b0;
      w_winner = r_ptr;
      for (int k = 0; k < p_num_ports; k++) begin
         v_idx = {1'b0, r_ptr} + k[SEL_W:0];
         if (v_idx >= NP_EXT) begin
            v_idx = v_idx - NP_EXT;
         end
         if (!w_found && in_val[v_idx[SEL_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = v_idx[SEL_W-1:0];
         end
      end
   end

   // Pointer successors for the two possible transfer sources.
   assign w_winner_inc = (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
   assign w_win_inc    = (r_win    == LAST_IDX) ? '0 : r_win    + 1'b1;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // State, pointer, lock and hold-off counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
         r_win   <= w_win_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state and grant decode: zero-delay pass-through from IDLE,
   // otherwise lock the winner and count the hold-off down in DELAY.
   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_win_next   = r_win;
      w_cnt_next   = r_cnt;
      w_out_val    = 1'b0;
      w_grant      = 1'b0;
      w_sel        = w_winner;
      case (r_state)
         ST_IDLE: begin
            w_sel = w_winner;
            if (w_found) begin
               if ((w_rand == 32'h0) && out_rdy) begin
                  w_out_val  = 1'b1;
                  w_grant    = 1'b1;
                  w_ptr_next = w_winner_inc;
               end else begin
                  w_state_next = ST_DELAY;
                  w_win_next   = w_winner;
                  w_cnt_next   = (w_rand == 32'h0) ? '0 : (w_rand[CNT_W-1:0] - CNT_ONE);
               end
            end
         end
         ST_DELAY: begin
            w_sel = r_win;
            if (r_cnt != '0) begin
               w_cnt_next = r_cnt - CNT_ONE;
            end else begin
               w_out_val = in_val[r_win];
               w_grant   = out_rdy;
               if (in_val[r_win] && out_rdy) begin
                  w_state_next = ST_IDLE;
                  w_ptr_next   = w_win_inc;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: handshakes are forced low while reset is held so nothing
   // can transfer during reset.
   // ------------------------------------------------------------------
   assign out_val = reset_n & w_out_val;
   assign out_sel = w_sel;
   assign out_msg = w_msg_arr[w_sel];

   generate
      for (gi = 0; gi < p_num_ports; gi++) begin : g_rdy
         assign in_rdy[gi] = reset_n & w_grant & (w_sel == SEL_W'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Optional source-protocol checker
   // ------------------------------------------------------------------
`ifdef VC_TEST_RAND_DELAY_ARB_CHECK_EN
   logic                r_err;
   logic [p_msg_sz-1:0] r_msg_snap;

   // Snapshot the locked message and flag any drop or change before transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err      <= 1'b0;
         r_msg_snap <= '0;
      end else begin
         if ((r_state == ST_IDLE) && (w_state_next == ST_DELAY)) begin
            r_msg_snap <= w_msg_arr[w_winner];
         end
         if ((r_state == ST_DELAY) &&
             (!in_val[r_win] || (w_msg_arr[r_win] != r_msg_snap))) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_test_rand_delay_arb.sv
// Bench for vc_test_rand_delay_arb: a zero-delay instance driven from a
// vector table, and a max-delay-3 instance exercised by directed corner
// sequences plus random traffic against a transaction-level model.
module tb_vc_test_rand_delay_arb;

   localparam logic [31:0] SEED = 32'hB7E1_5163;
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // zero-delay instance
   logic [3:0]  in_val0, in_rdy0;
   logic [31:0] in_msg0;
   logic        out_val0, out_rdy0, err0;
   logic [7:0]  out_msg0;
   logic [1:0]  out_sel0;
   logic [31:0] rand0;

   // delay-3 instance
   logic [3:0]  in_val3, in_rdy3;
   logic [31:0] in_msg3;
   logic        out_val3, out_rdy3, err3;
   logic [7:0]  out_msg3;
   logic [1:0]  out_sel3;
   logic [31:0] rand3;
   logic [7:0]  m3 [4];

   assign in_msg0 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
   assign in_msg3 = {m3[3], m3[2], m3[1], m3[0]};

   vc_test_rand_delay_arb #(
      .p_num_ports (4), .p_msg_sz (8), .p_max_delay (0), .p_seed (SEED)
   ) dut0 (
      .clk (clk), .reset_n (rst_n),
      .in_val (in_val0), .in_rdy (in_rdy0), .in_msg (in_msg0),
      .out_val (out_val0), .out_rdy (out_rdy0), .out_msg (out_msg0),
      .out_sel (out_sel0), .rand_num (rand0), .err (err0)
   );

   vc_test_rand_delay_arb #(
      .p_num_ports (4), .p_msg_sz (8), .p_max_delay (3), .p_seed (SEED)
   ) dut3 (
      .clk (clk), .reset_n (rst_n),
      .in_val (in_val3), .in_rdy (in_rdy3), .in_msg (in_msg3),
      .out_val (out_val3), .out_rdy (out_rdy3), .out_msg (out_msg3),
      .out_sel (out_sel3), .rand_num (rand3), .err (err3)
   );

   // Reference random sequence: seed on reset, one Galois step per cycle.
   logic [31:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= SEED;
      else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'h0);
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int p, input logic [3:0] v);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_val0 = '0; out_rdy0 = 1'b0; in_val3 = '0; out_rdy3 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance (bounded) to a negedge whose current rand_num equals target.
   task automatic wait_rand(input int target);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if ((m_lfsr % 4) == target) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("wait_rand_found", ok, 1'b1);
   endtask

   // Bounded wait for out_val3; returns whether it was seen.
   task automatic wait_val3(output logic got);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (out_val3) begin got = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [3:0] val;
      logic       rdy;
      logic       exp_val;
      logic [3:0] exp_rdy;
      logic [1:0] exp_sel;
   } vec_t;

   vec_t        tbl [15];
   logic [31:0] seq1 [40];
   int          hist [4];

   initial begin
      logic       got;
      logic [3:0] v3, cleared;
      logic       r3;
      int         m_busy, m_ptr, m_win, m_due, nx, pend, psrc, er, w;
      int         exp_sel, sel_chk, diffs;
      logic       exp_val;
      logic [3:0] exp_rdy;

      // Vectors for the zero-delay instance, applied in order from reset.
      tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
      tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
      tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
      tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3};
      tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
      tbl[5]  = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1};
      tbl[6]  = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1};
      tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0};
      tbl[8]  = '{4'b1001, 1'b0, 1'b0, 4'b0000, 2'd3};
      tbl[9]  = '{4'b1001, 1'b0, 1'b1, 4'b0000, 2'd3};
      tbl[10] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};
      tbl[11] = '{4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0};
      tbl[12] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};
      tbl[13] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
      tbl[14] = '{4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1};

      for (int i = 0; i < 4; i++) begin m3[i] = 8'h00; hist[i] = 0; end

      // Reset state, with requests and sink ready held to prove gating.
      rst_n = 1'b0;
      in_val0 = 4'b1111; out_rdy0 = 1'b1;
      in_val3 = 4'b1111; out_rdy3 = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      chk("reset_out_val0", out_val0, 1'b0);
      chk("reset_in_rdy0", in_rdy0, 4'b0000);
      chk("reset_out_val3", out_val3, 1'b0);
      chk("reset_in_rdy3", in_rdy3, 4'b0000);
      chk("reset_rand3", rand3, SEED % 4);
      chk("reset_rand0", rand0, 32'h0);
      chk("reset_err3", err3, 1'b0);
      do_reset();

      // Record the bounded random sequence from reset and check the model.
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         seq1[c] = rand3;
         chk("rand_seq", rand3, m_lfsr % 4);
      end

      // Table-driven zero-delay checks.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         in_val0 = tbl[i].val; out_rdy0 = tbl[i].rdy;
         #1;
         chk($sformatf("tbl%0d_out_val", i), out_val0, tbl[i].exp_val);
         chk($sformatf("tbl%0d_in_rdy", i), in_rdy0, tbl[i].exp_rdy);
         chk($sformatf("tbl%0d_rand", i), rand0, 32'h0);
         if (tbl[i].val != 4'b0000) begin
            chk($sformatf("tbl%0d_out_sel", i), out_sel0, tbl[i].exp_sel);
            chk($sformatf("tbl%0d_out_msg", i), out_msg0, 8'hA0 + tbl[i].exp_sel);
         end
      end
      @(negedge clk);
      in_val0 = '0;

      // Lock: source 2 latched, source 0 arrives during the hold-off.
      do_reset();
      wait_rand(3);
      m3[2] = 8'h5C; m3[0] = 8'h11;
      in_val3 = 4'b0100; out_rdy3 = 1'b1;
      #1;
      chk("lock_c0_val", out_val3, 1'b0);
      chk("lock_c0_sel", out_sel3, 2'd2);
      @(negedge clk); in_val3 = 4'b0101; #1;
      chk("lock_c1_val", out_val3, 1'b0);
      chk("lock_c1_sel", out_sel3, 2'd2);
      @(negedge clk); #1;
      chk("lock_c2_val", out_val3, 1'b0);
      @(negedge clk); #1;
      chk("lock_c3_val", out_val3, 1'b1);
      chk("lock_c3_sel", out_sel3, 2'd2);
      chk("lock_c3_rdy", in_rdy3, 4'b0100);
      chk("lock_c3_msg", out_msg3, 8'h5C);
      @(negedge clk); in_val3 = 4'b0001;
      wait_val3(got);
      chk("lock_second_seen", got, 1'b1);
      chk("lock_second_sel", out_sel3, 2'd0);
      chk("lock_second_msg", out_msg3, 8'h11);
      @(negedge clk); in_val3 = '0;

      // Backpressure after the hold-off expires.
      do_reset();
      wait_rand(2);
      m3[1] = 8'h3C;
      in_val3 = 4'b0010; out_rdy3 = 1'b0;
      #1; chk("bp_c0_val", out_val3, 1'b0);
      @(negedge clk); #1; chk("bp_c1_val", out_val3, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("bp_hold_val", out_val3, 1'b1);
         chk("bp_hold_msg", out_msg3, 8'h3C);
         chk("bp_hold_sel", out_sel3, 2'd1);
         chk("bp_hold_rdy", in_rdy3, 4'b0000);
      end
      @(negedge clk); out_rdy3 = 1'b1; #1;
      chk("bp_release_val", out_val3, 1'b1);
      chk("bp_release_rdy", in_rdy3, 4'b0010);
      @(negedge clk);
      m3[0] = 8'h40; m3[2] = 8'h42; m3[3] = 8'h43;
      in_val3 = 4'b1111;
      wait_val3(got);
      chk("bp_next_seen", got, 1'b1);
      chk("bp_next_sel", out_sel3, 2'd2);
      @(negedge clk); in_val3 = '0;

      // Reset asserted in the middle of a hold-off.
      do_reset();
      wait_rand(3);
      m3[2] = 8'h77;
      in_val3 = 4'b0100; out_rdy3 = 1'b1;
      @(negedge clk); #1;
      chk("rst_mid_pre_val", out_val3, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_val", out_val3, 1'b0);
      chk("rst_mid_rdy", in_rdy3, 4'b0000);
      chk("rst_mid_rand", rand3, SEED % 4);
      @(negedge clk);
      rst_n = 1'b1;
      m3[0] = 8'h70; m3[1] = 8'h71; m3[3] = 8'h73;
      in_val3 = 4'b1111;
      wait_val3(got);
      chk("rst_mid_after_seen", got, 1'b1);
      chk("rst_mid_after_sel", out_sel3, 2'd0);
      @(negedge clk); in_val3 = '0;

      // Protocol checker: source drops its valid while locked.
      do_reset();
      wait_rand(3);
      in_val3 = 4'b0010; out_rdy3 = 1'b1;
      @(negedge clk); in_val3 = 4'b0000;
      @(negedge clk); #1;
`ifdef VC_TEST_RAND_DELAY_ARB_CHECK_EN
      chk("chk_err_set", err3, 1'b1);
      @(negedge clk); #1;
      chk("chk_err_sticky", err3, 1'b1);
`else
      chk("chk_err_tied", err3, 1'b0);
      @(negedge clk); #1;
      chk("chk_err_tied2", err3, 1'b0);
`endif
      do_reset();
      #1;
      chk("chk_err_cleared", err3, 1'b0);

      // Random traffic against the transaction-level model.
      do_reset();
      m_busy = 0; m_ptr = 0; m_win = 0; m_due = 0; nx = 0; pend = 0; psrc = 0;
      v3 = '0;
      for (int c = 0; c < 4000 && nx < 200; c++) begin
         if (c > 0) @(negedge clk);
         cleared = '0;
         if (pend != 0) begin v3[psrc] = 1'b0; cleared[psrc] = 1'b1; pend = 0; end
         for (int i = 0; i < 4; i++) begin
            if (!v3[i] && !cleared[i] && $urandom_range(0, 2) == 0) begin
               v3[i] = 1'b1;
               m3[i] = 8'($urandom);
            end
         end
         r3 = ($urandom_range(0, 3) != 0);
         in_val3 = v3; out_rdy3 = r3;
         #1;
         er = int'(m_lfsr % 4);
         chk("rnd_rand", rand3, er);
         exp_val = 1'b0; exp_sel = 0; sel_chk = 0;
         if (m_busy == 0) begin
            if (v3 != 4'b0000) begin
               w = rr_pick(m_ptr, v3);
               hist[er]++;
               exp_sel = w; sel_chk = 1;
               if (er == 0 && r3) begin
                  exp_val = 1'b1;
               end else begin
                  m_busy = 1; m_win = w;
                  m_due = c + ((er == 0) ? 1 : er);
               end
            end
         end else begin
            exp_sel = m_win; sel_chk = 1;
            exp_val = (c >= m_due) ? v3[m_win] : 1'b0;
         end
         exp_rdy = (sel_chk != 0 && (exp_val || (m_busy != 0 && c >= m_due)) && r3)
                   ? (4'b0001 << exp_sel) : 4'b0000;
         chk("rnd_out_val", out_val3, exp_val);
         chk("rnd_in_rdy", in_rdy3, exp_rdy);
         if (sel_chk != 0) begin
            chk("rnd_out_sel", out_sel3, exp_sel);
            chk("rnd_out_msg", out_msg3, m3[exp_sel]);
         end
         if (exp_val && r3) begin
            m_ptr = (exp_sel + 1) % 4;
            m_busy = 0;
            nx++;
            pend = 1; psrc = exp_sel;
         end
      end
      chk("rnd_xfer_count", nx, 200);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rnd_holdoff_%0d_seen", i), (hist[i] > 0), 1'b1);
      end
      chk("rnd_err_clean", err3, 1'b0);

      // Same seed after reset must replay the same bounded sequence.
      do_reset();
      diffs = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (rand3 !== seq1[c]) diffs++;
      end
      chk("repro_diffs", diffs, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
